// File: rtl/audio_dac_feeder.sv
// Avalon-MM master feeding stereo pairs into the audio codec core (fifospace-polled credit).
// Optional underrun counter port is compiled in when AUDIO_FEEDER_UNDERRUN_EN is defined.
module audio_dac_feeder #(
  parameter int SAMPLE_W     = 16,
  parameter int AUDIO_W      = 24,
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 64,
  parameter int FIFO_DEPTH   = 128
) (
  input  logic                sys_clk_clk,
  input  logic                sys_reset_reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                enable,
  output logic [1:0]          audio_master_address,
  output logic                audio_master_chipselect,
  output logic                audio_master_read,
  output logic                audio_master_write,
  output logic [31:0]         audio_master_writedata,
  input  logic [31:0]         audio_master_readdata,
`ifdef AUDIO_FEEDER_UNDERRUN_EN
  output logic [15:0]         underrun_count,
`endif
  output logic                init_done
);

  localparam int CNT_W = $clog2(POLL_GAP + READ_LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 2);

  localparam logic [1:0]  ADDR_CTRL      = 2'd0;
  localparam logic [1:0]  ADDR_FIFOSPACE = 2'd1;
  localparam logic [1:0]  ADDR_LEFT      = 2'd2;
  localparam logic [1:0]  ADDR_RIGHT     = 2'd3;
  localparam logic [31:0] CTRL_CW        = 32'h0000_0008;

  typedef enum logic [3:0] {
    S_INIT_SET,
    S_INIT_CLR,
    S_POLL,
    S_WAIT_RD,
    S_CHECK,
    S_GAP,
    S_READY,
    S_WR_L,
    S_WR_R
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_wslc;
  logic [7:0]          r_wsrc;
  logic [7:0]          r_credit;
  logic [7:0]          w_credit_chk;
  logic                r_in_ready;
  logic                w_full;
  logic [SAMPLE_W-1:0] r_left;
  logic [SAMPLE_W-1:0] r_right;

  logic                r_cs;
  logic                r_rd;
  logic                r_wr;
  logic [1:0]          r_addr;
  logic [31:0]         r_wdata;
  logic                r_init_done;

  logic                w_cs_d;
  logic                w_rd_d;
  logic                w_wr_d;
  logic [1:0]          w_addr_d;
  logic [31:0]         w_wdata_d;

  logic                w_unused_rd;

  // Left-justify into the codec word, then sign-extend to the 32-bit bus.
  function automatic logic [31:0] f_ext(input logic [SAMPLE_W-1:0] s);
    return {{(32-AUDIO_W){s[SAMPLE_W-1]}}, s, {(AUDIO_W-SAMPLE_W){1'b0}}};
  endfunction

  assign w_full       = ~r_in_ready;
  assign w_credit_chk = (r_wslc < r_wsrc) ? r_wslc : r_wsrc;
  assign w_unused_rd  = &{1'b0, audio_master_readdata[15:0]};

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      r_state <= S_INIT_SET;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT_SET: w_state_next = S_INIT_CLR;
      S_INIT_CLR: w_state_next = S_POLL;
      S_POLL: begin
        if (enable) begin
          w_state_next = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (r_cnt == RD_LAST) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: w_state_next = (w_credit_chk == 8'd0) ? S_GAP : S_READY;
      S_GAP: begin
        // POLL itself is the last idle cycle of the gap.
        if (enable && (r_cnt == GAP_LAST)) begin
          w_state_next = S_POLL;
        end
      end
      S_READY: begin
        if (w_full && enable) begin
          w_state_next = S_WR_L;
        end
      end
      S_WR_L: w_state_next = S_WR_R;
      S_WR_R: w_state_next = (r_credit <= 8'd1) ? S_POLL : S_READY;
      default: w_state_next = S_INIT_SET;
    endcase
  end

  always_comb begin
    w_rd_d    = 1'b0;
    w_wr_d    = 1'b0;
    w_addr_d  = ADDR_CTRL;
    w_wdata_d = 32'h0;
    case (r_state)
      S_INIT_SET: begin
        w_wr_d    = 1'b1;
        w_addr_d  = ADDR_CTRL;
        w_wdata_d = CTRL_CW;
      end
      S_INIT_CLR: begin
        w_wr_d   = 1'b1;
        w_addr_d = ADDR_CTRL;
      end
      S_POLL: begin
        if (enable) begin
          w_rd_d   = 1'b1;
          w_addr_d = ADDR_FIFOSPACE;
        end
      end
      S_WR_L: begin
        w_wr_d    = 1'b1;
        w_addr_d  = ADDR_LEFT;
        w_wdata_d = f_ext(r_left);
      end
      S_WR_R: begin
        w_wr_d    = 1'b1;
        w_addr_d  = ADDR_RIGHT;
        w_wdata_d = f_ext(r_right);
      end
      default: ;
    endcase
    w_cs_d = w_rd_d | w_wr_d;
  end

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      r_cs        <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= 2'd0;
      r_wdata     <= 32'h0;
      r_init_done <= 1'b0;
    end else begin
      r_cs    <= w_cs_d;
      r_rd    <= w_rd_d;
      r_wr    <= w_wr_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      if (r_state == S_INIT_CLR) begin
        r_init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT_RD) || ((r_state == S_GAP) && enable)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      r_wslc   <= 8'd0;
      r_wsrc   <= 8'd0;
      r_credit <= 8'd0;
    end else begin
      if ((r_state == S_WAIT_RD) && (r_cnt == RD_LAST)) begin
        r_wslc <= audio_master_readdata[31:24];
        r_wsrc <= audio_master_readdata[23:16];
      end
      if (r_state == S_CHECK) begin
        r_credit <= w_credit_chk;
      end else if ((r_state == S_WR_R) && (r_credit != 8'd0)) begin
        r_credit <= r_credit - 8'd1;
      end
    end
  end

  // Holding register: emptied by the right-channel write, refilled by the stream.
  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      r_in_ready <= 1'b1;
      r_left     <= '0;
      r_right    <= '0;
    end else if (r_state == S_WR_R) begin
      r_in_ready <= 1'b1;
    end else if (in_valid && r_in_ready) begin
      r_in_ready <= 1'b0;
      r_left     <= in_left;
      r_right    <= in_right;
    end
  end

`ifdef AUDIO_FEEDER_UNDERRUN_EN
  localparam logic [7:0] DEPTH_B = 8'(FIFO_DEPTH);

  logic        r_pair_seen;
  logic [15:0] r_underrun;

  // A completely empty DAC FIFO after data has flowed means the codec ran dry.
  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      r_pair_seen <= 1'b0;
      r_underrun  <= 16'h0;
    end else begin
      if (r_state == S_WR_R) begin
        r_pair_seen <= 1'b1;
      end
      if ((r_state == S_CHECK) && r_pair_seen &&
          ((r_wslc == DEPTH_B) || (r_wsrc == DEPTH_B)) &&
          (r_underrun != 16'hFFFF)) begin
        r_underrun <= r_underrun + 16'd1;
      end
    end
  end

  assign underrun_count = r_underrun;
`endif

  assign in_ready                = r_in_ready;
  assign audio_master_address    = r_addr;
  assign audio_master_chipselect = r_cs;
  assign audio_master_read       = r_rd;
  assign audio_master_write      = r_wr;
  assign audio_master_writedata  = r_wdata;
  assign init_done               = r_init_done;

endmodule
